// File: rtl/modulo_unit.sv
// ---------------------------------------------------------------------------
// modulo_unit
//   Sequential unsigned remainder unit: res = a mod b for WIDTH-bit operands.
//   Uses restoring long division that retires RADIX_BITS quotient bits per
//   clock. With the default configuration, a result is ready 8 edges after
//   the edge that accepts go.
//
//   Optional build macro: MODULO_EARLY_EXIT_EN
//     When this macro is defined, an operation with b != 0 and a < b finishes
//     on the accepting edge and returns res = a. The results are the same in
//     both builds; only the latency differs.
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous reset, active low
//   go    in   1      start request. It is ignored while the unit is busy.
//   a     in   WIDTH  dividend, captured when go is accepted
//   b     in   WIDTH  divisor, captured when go is accepted
//   ready out  1      result valid / unit idle
//   error out  1      divide-by-zero flag for the last operation
//   res   out  WIDTH  unsigned remainder. A divide by zero returns a.
// ---------------------------------------------------------------------------
module modulo_unit #(
    parameter int WIDTH      = 16,
    parameter int RADIX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res
);

    localparam int ITER  = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(ITER) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    logic [1:0]       state_r;
    logic [WIDTH-1:0] div_r;    // dividend; the next bits to consume are at the MSB end
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] rem_r;    // partial remainder; always < b_r between steps
    logic [CNT_W-1:0] cnt_r;
    logic             ready_r;
    logic             error_r;
    logic [WIDTH-1:0] res_r;

    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] step_div_s;

    assign ready = ready_r;
    assign error = error_r;
    assign res   = res_r;

    // One BUSY iteration: shift RADIX_BITS dividend bits into the remainder, restoring after each one
    always_comb begin
        step_rem_s = {1'b0, rem_r};
        step_div_s = div_r;
        for (int k = 0; k < RADIX_BITS; k++) begin
            // The remainder is below b < 2^WIDTH, so the shifted value fits in WIDTH+1 bits
            step_rem_s = {step_rem_s[WIDTH-1:0], step_div_s[WIDTH-1]};
            step_div_s = {step_div_s[WIDTH-2:0], 1'b0};
            if (step_rem_s >= {1'b0, b_r}) begin
                step_rem_s = step_rem_s - {1'b0, b_r};
            end else begin
                step_rem_s = step_rem_s;
            end
        end
    end

    // Control FSM and datapath registers; all outputs are registered here
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            div_r   <= W_ZERO;
            b_r     <= W_ZERO;
            rem_r   <= W_ZERO;
            cnt_r   <= CNT_ZERO;
            ready_r <= 1'b0;
            error_r <= 1'b0;
            res_r   <= W_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        div_r   <= a;
                        b_r     <= b;
                        ready_r <= 1'b0;
                        error_r <= 1'b0;
                        if (b == W_ZERO) begin
                            // Divide by zero finishes at once and passes the dividend through
                            state_r <= ST_DONE;
                            error_r <= 1'b1;
                            res_r   <= a;
                            ready_r <= 1'b1;
`ifdef MODULO_EARLY_EXIT_EN
                        end else if (a < b) begin
                            state_r <= ST_DONE;
                            res_r   <= a;
                            ready_r <= 1'b1;
`endif
                        end else begin
                            state_r <= ST_BUSY;
                            rem_r   <= W_ZERO;
                            cnt_r   <= CNT_ZERO;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_BUSY: begin
                    // A go request here is deliberately ignored
                    rem_r <= step_rem_s[WIDTH-1:0];
                    div_r <= step_div_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        res_r   <= step_rem_s[WIDTH-1:0];
                        ready_r <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    error_r <= 1'b0;
                    res_r   <= W_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_unit.sv
module tb_modulo_unit;

    localparam int W   = 16;
    localparam int R   = 2;
    localparam int NIT = W / R;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         error;
    logic [W-1:0] res;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_err;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    modulo_unit #(.WIDTH(W), .RADIX_BITS(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .a    (a),
        .b    (b),
        .ready(ready),
        .error(error),
        .res  (res)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Reference: remainder by plain arithmetic; b==0 returns a
    function automatic logic [W-1:0] model_res(input logic [W-1:0] av, input logic [W-1:0] bv);
        if (bv == 0) return av;
        return av % bv;
    endfunction

    // Edges counted from and including the edge that accepts go
    function automatic int model_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
        if (bv == 0) return 1;
`ifdef MODULO_EARLY_EXIT_EN
        if (av < bv) return 1;
`endif
        return NIT + 1;
    endfunction

    // Called #1 after a posedge. Returns the number of edges until ready is seen.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
        go = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        go = 1'b0; a = ~av; b = ~bv;    // operands must have been latched
        lat = 1;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat;
        run_op(av, bv, lat);
        chk({name, ".res"}, 32'(res), 32'(model_res(av, bv)));
        chk({name, ".err"}, 32'(error), 32'(bv == 0));
        chk({name, ".lat"}, 32'(lat), 32'(model_lat(av, bv)));
    endtask

    initial begin
        int lat;
        int pulses;
        int consec;
        logic prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{16'd19,    16'd4,     16'd3,  1'b0};
        vecs[1]  = '{16'd7,     16'd0,     16'd7,  1'b1};
        vecs[2]  = '{16'd9,     16'd2,     16'd1,  1'b0};
        vecs[3]  = '{16'hFFFF,  16'h00FF,  16'd0,  1'b0};
        vecs[4]  = '{16'hFFFF,  16'hFFFE,  16'd1,  1'b0};
        vecs[5]  = '{16'h8000,  16'd3,     16'd2,  1'b0};
        vecs[6]  = '{16'd0,     16'd0,     16'd0,  1'b1};
        vecs[7]  = '{16'd0,     16'd5,     16'd0,  1'b0};
        vecs[8]  = '{16'd5,     16'd9,     16'd5,  1'b0};
        vecs[9]  = '{16'd100,   16'd100,   16'd0,  1'b0};
        vecs[10] = '{16'd100,   16'd7,     16'd2,  1'b0};
        vecs[11] = '{16'd1,     16'hFFFF,  16'd1,  1'b0};
        vecs[12] = '{16'hFFFF,  16'd1,     16'd0,  1'b0};

        rst = 1'b0; go = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ready", 32'(ready), 32'd0);
        chk("reset.error", 32'(error), 32'd0);
        chk("reset.res",   32'(res),   32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle.ready", 32'(ready), 32'd0);

        // Table-driven directed vectors, plus a check that the result holds for one idle cycle
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d.res", i), 32'(res), 32'(vecs[i].exp_res));
            chk($sformatf("vec%0d.err", i), 32'(error), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.lat", i), 32'(lat), 32'(model_lat(vecs[i].a, vecs[i].b)));
            @(posedge clk); #1;
            chk($sformatf("vec%0d.hold_rdy", i), 32'(ready), 32'd1);
            chk($sformatf("vec%0d.hold_res", i), 32'(res), 32'(vecs[i].exp_res));
        end

        // Exhaustive small sweep
        for (int ia = 0; ia < 20; ia++) begin
            for (int ib = 1; ib < 20; ib++) begin
                check_op($sformatf("sweep_%0d_%0d", ia, ib), W'(ia), W'(ib));
            end
        end

        // A go pulse during BUSY must not disturb the operation in flight
        go = 1'b1; a = 16'd100; b = 16'd7;
        @(posedge clk); #1;
        go = 1'b0; a = '0; b = '0;
        lat = 1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        go = 1'b1; a = 16'd50; b = 16'd9;
        @(posedge clk); #1; lat++;
        go = 1'b0;
        while (!ready && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("busy_go.res", 32'(res), 32'd2);
        chk("busy_go.lat", 32'(lat), 32'(NIT + 1));

        // Reset part-way through BUSY
        go = 1'b1; a = 16'd12345; b = 16'd77;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst.ready", 32'(ready), 32'd0);
        chk("midrst.error", 32'(error), 32'd0);
        chk("midrst.res",   32'(res),   32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_op("after_rst", 16'd10, 16'd3);

        // With go held high, ready is a one-cycle pulse every NIT+1 edges
        go = 1'b1; a = 16'd20; b = 16'd6;
        pulses = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 4 * (NIT + 1); i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                pulses++;
                if (prev) consec++;
                chk("held.res", 32'(res), 32'd2);
            end
            prev = ready;
        end
        go = 1'b0;
        chk("held.pulses", 32'(pulses), 32'd4);
        chk("held.consec", 32'(consec), 32'd0);
        @(posedge clk); #1;

        // Randomised operands checked against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = W'(0);
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = ra + W'($urandom_range(0, 3));
                default: rb = W'($urandom);
            endcase
            check_op($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modulo_unit.md
Name: modulo_unit

Overview:
- Sequential unsigned integer remainder unit: computes res = a mod b for WIDTH-bit operands.
- Uses multi-bit-per-cycle restoring long division, so a 16-bit result completes within 9 clock edges of the start pulse.
- Sits as a helper datapath block under a controlling FSM that pulses go, waits for ready, then reads res/error.

Parameters:
- WIDTH, 16, operand and result width in bits.
- RADIX_BITS, 2, quotient bits retired per clock; must divide WIDTH evenly. Iteration count N = WIDTH/RADIX_BITS (8 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk edge).
- go  input  1  start request; sampled on rising edge.
- a  input  WIDTH  dividend; captured when go is accepted.
- b  input  WIDTH  divisor; captured when go is accepted.
- ready  output  1  result valid / unit idle.
- error  output  1  divide-by-zero flag for the last operation.
- res  output  WIDTH  remainder, unsigned.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, ready=0, error=0, res=0, internal registers cleared. Reset dominates go and aborts any operation in flight.
- States: IDLE, BUSY, DONE.
- IDLE/DONE + go==1:
  - Latch a and b, clear ready and error.
  - If b==0: go straight to DONE on that same edge with error=1, res=a, ready=1 (latency 1 edge).
  - Otherwise enter BUSY with remainder accumulator=0 and iteration counter=0.
- IDLE/DONE + go==0: hold all outputs.
- BUSY, each edge:
  - Shift the next RADIX_BITS dividend bits (MSB first) into the remainder.
  - For each sub-step, subtract b if remainder >= b.
  - Increment the counter. On the N-th BUSY edge, write the final remainder to res, set ready=1, go to DONE.
- Latency: go sampled at edge 0; ready=1 after edge N (8 edges for the defaults). Ready stays high and res stays stable until the next accepted go.
- go while BUSY is ignored; the operands in flight are unaffected.
- go held high continuously: in DONE it restarts a new operation each time DONE is reached; ready pulses high for one cycle only.
- Arithmetic:
  - All unsigned.
  - The remainder datapath is WIDTH+1 bits internally so the compare/subtract cannot overflow.
  - res < b always when error==0.
- a < b gives res=a; a==b gives res=0; a=0 gives res=0 (error still set if b=0).

Optional Feature:
- Macro MODULO_EARLY_EXIT_EN.
- When defined: in IDLE/DONE with go==1, b!=0 and a<b, the unit goes directly to DONE with res=a, ready=1, error=0 after 1 edge (skips BUSY).
- Without it: every b!=0 operation takes the full N BUSY edges, giving fixed latency.
- Results are identical in both builds; only latency differs.

Test Plan:
- Exhaustive small sweep: a=0..19, b=1..19, pulse go for one cycle. Within 10 cycles ready=1, error=0, res==a%b (e.g. a=19, b=4 gives res=3).
- Divide by zero: a=7, b=0, go pulse. After 1 edge ready=1, error=1, res=7. Then a=9, b=2 gives error=0, res=1.
- Full width: a=16'hFFFF, b=16'h00FF gives res=0. a=16'hFFFF, b=16'hFFFE gives res=1. a=16'h8000, b=3 gives res=2. Ready asserts exactly 8 edges after go (macro off).
- go during BUSY: start a=100, b=7, then pulse go with a=50, b=9 at cycle 3. res=2 (ignored request). Ready timing is unchanged.
- Reset mid-operation: drive rst=0 at cycle 4 of BUSY. Next edge gives ready=0, error=0, res=0, state IDLE. A later go with a=10, b=3 gives res=1.
- Early exit (MODULO_EARLY_EXIT_EN defined): a=5, b=9 gives ready=1, res=5 after 1 edge. With the macro undefined the same stimulus gives ready after 8 edges.
